// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the divide request stage.
// Op encoding follows RISC-V M-extension funct3[1:0].
package div_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_DONE   = 2'b10
  } div_state_e;

  // Signed variants have op[0] clear.
  function automatic logic div_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  // Remainder variants have op[1] set.
  function automatic logic div_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/Division.sv
// Division: combinational unsigned restoring array divider.
// A zero divisor naturally yields quotient all-ones and remainder equal to the dividend.
module Division #(
  parameter int l = 16
) (
  input  logic [l-1:0] i_dividend,
  input  logic [l-1:0] i_divisor,
  output logic [l-1:0] o_quotient,
  output logic [l-1:0] o_remainder
);

  logic [l:0] w_rem;

  // One restoring subtract stage per quotient bit, MSB first.
  always_comb begin
    w_rem      = '0;
    o_quotient = '0;
    for (int i = l - 1; i >= 0; i--) begin
      w_rem = {w_rem[l-1:0], i_dividend[i]};
      if (w_rem >= {1'b0, i_divisor}) begin
        w_rem         = w_rem - {1'b0, i_divisor};
        o_quotient[i] = 1'b1;
      end
    end
    o_remainder = w_rem[l-1:0];
  end

endmodule

// File: rtl/div_sign_fixup.sv
// div_sign_fixup: turns the unsigned divider outputs back into a RISC-V result.
// Handles sign restoration and the divide-by-zero / MIN/-1 special cases.
// DIV_FLAGS_EN: when defined, the dbz/ovf flags are also presented as outputs.
module div_sign_fixup
  import div_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_r,
  input  div_op_e         i_op,
  input  logic            i_sign_a,
  input  logic            i_sign_b,
  input  logic            i_dbz,
  input  logic            i_ovf,
  input  logic [XLEN-1:0] i_a,
  output logic [XLEN-1:0] o_result
`ifdef DIV_FLAGS_EN
  ,
  output logic            o_dbz,
  output logic            o_ovf
`endif
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  // Sign fixup first, then special cases override; signs are already zero for unsigned ops.
  always_comb begin
    w_q_fix = (i_sign_a ^ i_sign_b) ? -i_q : i_q;
    w_r_fix = i_sign_a ? -i_r : i_r;
    if (i_dbz) begin
      w_q_fix = '1;
      w_r_fix = i_a;
    end else if (i_ovf) begin
      w_q_fix = MIN_VAL;
      w_r_fix = '0;
    end
    o_result = div_is_rem(i_op) ? w_r_fix : w_q_fix;
  end

`ifdef DIV_FLAGS_EN
  assign o_dbz = i_dbz;
  assign o_ovf = i_ovf;
`endif

endmodule

// File: rtl/div_request_stage.sv
// div_request_stage: valid/ready request stage in front of the combinational divider.
// Operand magnitudes are registered and held for SETTLE_CYCLES edges before sampling.
// DIV_FLAGS_EN: when defined, adds registered out_dbz/out_ovf outputs.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | waiting for a request, in_ready high
// ST_SETTLE | divider inputs held, counting settle edges
// ST_DONE   | result valid, waiting for out_ready
module div_request_stage
  import div_pkg::*;
#(
  parameter int XLEN          = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
`ifdef DIV_FLAGS_EN
  ,
  output logic            out_dbz,
  output logic            out_ovf
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      r_state;
  div_state_e      w_state_next;
  div_op_e         r_op;
  logic            r_sign_a;
  logic            r_sign_b;
  logic [XLEN-1:0] r_mag_a;
  logic [XLEN-1:0] r_mag_b;
  logic [XLEN-1:0] r_a;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_result;

  div_op_e         w_op;
  logic            w_accept;
  logic            w_last;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic            w_dbz;
  logic            w_ovf;
  logic [XLEN-1:0] w_result;

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_op       = div_op_e'(in_op);
  assign w_sign_a   = in_a[XLEN-1] & div_is_signed(w_op);
  assign w_sign_b   = in_b[XLEN-1] & div_is_signed(w_op);
  assign w_mag_a    = w_sign_a ? -in_a : in_a;
  assign w_mag_b    = w_sign_b ? -in_b : in_b;
  assign w_last     = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

  // Zero magnitude means zero divisor; MIN / -1 shows up as |a|==MIN, |b|==1 with both signs set.
  assign w_dbz      = (r_mag_b == '0);
  assign w_ovf      = r_sign_a & r_sign_b & (r_mag_a == MIN_VAL) & (r_mag_b == XLEN'(1));

  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;

  Division #(.l(XLEN)) u_division (
    .i_dividend  (r_mag_a),
    .i_divisor   (r_mag_b),
    .o_quotient  (w_q),
    .o_remainder (w_r)
  );

`ifdef DIV_FLAGS_EN
  logic w_flag_dbz;
  logic w_flag_ovf;
  logic r_dbz;
  logic r_ovf;
`endif

  div_sign_fixup #(.XLEN(XLEN)) u_fixup (
    .i_q      (w_q),
    .i_r      (w_r),
    .i_op     (r_op),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .i_dbz    (w_dbz),
    .i_ovf    (w_ovf),
    .i_a      (r_a),
    .o_result (w_result)
`ifdef DIV_FLAGS_EN
    ,
    .o_dbz    (w_flag_dbz),
    .o_ovf    (w_flag_ovf)
`endif
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: single request in flight.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_state_next = ST_SETTLE;
      ST_SETTLE: if (w_last)    w_state_next = ST_DONE;
      ST_DONE:   if (out_ready) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Capture operands on accept, count settle edges, sample the result on the final edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= DIV_OP_DIV;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_mag_a  <= w_mag_a;
      r_mag_b  <= w_mag_b;
      r_a      <= in_a;
      r_cnt    <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_result <= w_result;
    end
  end

`ifdef DIV_FLAGS_EN
  // Flags are registered alongside the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_dbz <= w_flag_dbz;
      r_ovf <= w_flag_ovf;
    end
  end

  assign out_dbz = r_dbz;
  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_div_request_stage.sv
// tb_div_request_stage: directed and randomized checks of div_request_stage against
// an arithmetic reference model of RISC-V divide semantics.
module tb_div_request_stage;

  localparam int XLEN = 16;
  localparam int SC   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
`ifdef DIV_FLAGS_EN
  logic            out_dbz;
  logic            out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_request_stage #(.XLEN(XLEN), .SETTLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef DIV_FLAGS_EN
    ,
    .out_dbz    (out_dbz),
    .out_ovf    (out_ovf)
`endif
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension divide semantics using plain integer arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b,
                                             output logic dbz, output logic ovf);
    bit sgn;
    bit rem;
    int sa;
    int sb;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    sgn = !op[0];
    rem = op[1];
    dbz = (b == 0);
    ovf = sgn && (a == 16'h8000) && (b == 16'hFFFF);
    if (dbz) begin
      q = 16'hFFFF;
      r = a;
    end else if (ovf) begin
      q = 16'h8000;
      r = 16'h0000;
    end else if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rem ? r : q;
  endfunction

  task automatic run_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input string tag, input int stall);
    int k;
    logic m_dbz;
    logic m_ovf;
    logic [XLEN-1:0] m_res;
    m_res = model(op, a, b, m_dbz, m_ovf);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check1({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!out_valid && k < 10);
    check({tag, "_lat"}, 16'(k), 16'(SC));
    check({tag, "_res"}, out_result, exp_res);
`ifdef DIV_FLAGS_EN
    check1({tag, "_dbz"}, out_dbz, m_dbz);
    check1({tag, "_ovf"}, out_ovf, m_ovf);
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = 16'($urandom);
      in_b     = 16'd1;
      @(posedge clk);
      @(negedge clk);
      check1({tag, "_stall_val"}, out_valid, 1'b1);
      check({tag, "_stall_res"}, out_result, exp_res);
      check1({tag, "_stall_rdy"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check1({tag, "_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_exp;
    logic            d_dbz;
    logic            d_ovf;
    logic            seen;
    int              sel;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 16'h0000);
`ifdef DIV_FLAGS_EN
    check1("rst_dbz", out_dbz, 1'b0);
    check1("rst_ovf", out_ovf, 1'b0);
`endif
    rst = 1'b0;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b1);

    run_req(2'b00, 16'hFFF9, 16'd2,   16'hFFFD, "div_m7_2",     0);
    run_req(2'b10, 16'hFFF9, 16'd2,   16'hFFFF, "rem_m7_2",     0);
    run_req(2'b01, 16'd100,  16'd7,   16'd14,   "divu_100_7",   0);
    run_req(2'b11, 16'd100,  16'd7,   16'd2,    "remu_100_7",   0);
    run_req(2'b01, 16'hFFFF, 16'd1,   16'hFFFF, "divu_ffff_1",  0);
    run_req(2'b00, 16'h1234, 16'd0,   16'hFFFF, "div_dbz",      0);
    run_req(2'b10, 16'h1234, 16'd0,   16'h1234, "rem_dbz",      0);
    run_req(2'b00, 16'h8000, 16'hFFFF, 16'h8000, "div_ovf",     0);
    run_req(2'b10, 16'h8000, 16'hFFFF, 16'h0000, "rem_ovf",     0);
    run_req(2'b01, 16'h8000, 16'hFFFF, 16'h0000, "divu_noovf",  0);
    run_req(2'b11, 16'h8000, 16'h0000, 16'h8000, "remu_dbz",    0);

    // Consumer stalls for 5 cycles while a new request is offered.
    run_req(2'b01, 16'd100, 16'd7, 16'd14, "stall5", 5);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check1("stall_no_extra", seen, 1'b0);

    // Reset during SETTLE discards the request.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_a     = 16'd50;
    in_b     = 16'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("rst_settle_rdy", in_ready, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check1("rst_settle_noval", seen, 1'b0);
    run_req(2'b01, 16'd9, 16'd3, 16'd3, "post_rst_divu", 0);

    // Randomized requests, biased toward the special cases.
    for (int t = 0; t < 40; t++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 16'($urandom);
      sel  = int'($urandom_range(0, 9));
      if (sel == 0) r_b = 16'h0000;
      else if (sel == 1) begin
        r_a = 16'h8000;
        r_b = 16'hFFFF;
      end else if (sel == 2) r_b = 16'($urandom_range(1, 5));
      else if (sel == 3) r_b = 16'hFFFF;
      else r_b = 16'($urandom);
      r_exp = model(r_op, r_a, r_b, d_dbz, d_ovf);
      run_req(r_op, r_a, r_b, r_exp, $sformatf("rand%0d", t), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
